// File: rtl/uart_tx_fifo.sv
// UART transmitter (8N1, LSB first) fed by a byte FIFO with a valid/ready push side.
// Define UART_TX_PARITY_EN to append an even-parity bit before the stop bit.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 10000000,
  parameter int BAUD_RATE  = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    tx_data,
  input  logic                          tx_valid,
  output logic                          tx_ready,
  output logic                          ser_tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int DIV = CLK_FREQ / BAUD_RATE;
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(DIV);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // FIFO: pointers carry one extra wrap bit so full and empty are distinguishable
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wptr_q, rptr_q, level;
  logic        full, empty, push, pop;
  logic [7:0]  rdata;

  assign level = wptr_q - rptr_q;
  assign full  = (level == (AW+1)'(FIFO_DEPTH));
  assign empty = (level == '0);
  assign push  = tx_valid && !full;
  assign rdata = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= tx_data;
  end

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          ser_q, ser_d;
  logic          bit_end;
`ifdef UART_TX_PARITY_EN
  logic          par_q, par_d;
`endif

  assign bit_end = (cnt_q == CW'(DIV-1));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    ser_d   = ser_q;
    pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    if (state_q != S_IDLE) cnt_d = bit_end ? '0 : cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          shift_d = rdata;
          ser_d   = 1'b0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^rdata;
`endif
        end
      end
      S_START: if (bit_end) begin
        state_d = S_DATA;
        idx_d   = '0;
        ser_d   = shift_q[0];
      end
      S_DATA: if (bit_end) begin
        if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
          state_d = S_PARITY;
          ser_d   = par_q;
`else
          state_d = S_STOP;
          ser_d   = 1'b1;
`endif
        end else begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + 3'd1;
          ser_d   = shift_q[1];
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: if (bit_end) begin
        state_d = S_STOP;
        ser_d   = 1'b1;
      end
`endif
      // Chaining straight into the next start bit keeps bursts gap-free
      S_STOP: if (bit_end) begin
        if (!empty) begin
          pop     = 1'b1;
          shift_d = rdata;
          ser_d   = 1'b0;
          state_d = S_START;
`ifdef UART_TX_PARITY_EN
          par_d   = ^rdata;
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        ser_d   = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      ser_q   <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      ser_q   <= ser_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign tx_ready   = !full;
  assign ser_tx     = ser_q;
  assign busy       = (state_q != S_IDLE) || !empty;
  assign fifo_level = level;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at DIV=10: frame vector table plus burst, full-FIFO and reset sequences.
module tb_uart_tx_fifo;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk, rst, tx_valid, tx_ready, ser_tx, busy;
  logic [7:0] tx_data;
  logic [4:0] fifo_level;

  uart_tx_fifo #(.CLK_FREQ(1152000), .BAUD_RATE(115200), .FIFO_DEPTH(16)) dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .ser_tx(ser_tx), .busy(busy), .fifo_level(fifo_level)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [7:0] mon_q [$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] frame;   // line bits in send order from bit 0: start, d0..d7, stop
    logic       par;
  } vec_t;
  vec_t vecs [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push1(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
  endtask

  function automatic logic [10:0] fr(input logic [9:0] f, input logic p);
`ifdef UART_TX_PARITY_EN
    return {1'b1, p, f[8:0]};
`else
    return {p, f};
`endif
  endfunction

  // Called #1 after edge X + pre, where X is the edge that launched the start bit
  task automatic check_frame(input logic [10:0] bits, input int pre, input string nm);
    for (int k = 0; k < NB; k++) begin
      tick(k == 0 ? 5 - pre : 5);
      chk(nm, ser_tx, bits[k]);
      if (k == NB - 1) begin
        tick(4);
        chk("busy_last_clk", busy, 1'b1);
        tick(1);
      end else begin
        tick(5);
      end
    end
  endtask

  // Line monitor: mid-bit sampling, bytes collected in arrival order
  initial begin
    logic [7:0] b;
    forever begin
      @(negedge clk);
      if (!rst && ser_tx === 1'b0) begin
        repeat (15) @(negedge clk);
        b[0] = ser_tx;
        for (int j = 1; j < 8; j++) begin
          repeat (10) @(negedge clk);
          b[j] = ser_tx;
        end
        repeat ((NB - 9) * 10) @(negedge clk);
        mon_q.push_back(b);
      end
    end
  end

  initial begin
    logic r;
    logic saw_full;
    int   i, g;

    vecs[0] = '{8'h55, 10'b1_01010101_0, 1'b0};
    vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
    vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
    vecs[3] = '{8'hA3, 10'b1_10100011_0, 1'b0};
    vecs[4] = '{8'h41, 10'b1_01000001_0, 1'b0};
    vecs[5] = '{8'h07, 10'b1_00000111_0, 1'b1};

    tx_valid = 1'b0;
    tx_data  = 8'h00;
    rst      = 1'b0;
    #2 rst = 1'b1;
    tick(2);
    chk("rst_ser", ser_tx, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_level", fifo_level, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(3);

    // Single frames from the table
    foreach (vecs[v]) begin
      mon_q.delete();
      push1(vecs[v].data);
      chk("lat_level", fifo_level, 5'd1);
      chk("lat_ser_high", ser_tx, 1'b1);
      tick(1);
      check_frame(fr(vecs[v].frame, vecs[v].par), 0, "frame_bit");
      chk("end_busy", busy, 1'b0);
      chk("end_ser", ser_tx, 1'b1);
      tick(2);
      chk("mon_cnt", mon_q.size(), 1);
      if (mon_q.size() >= 1) chk("mon_byte", mon_q[0], vecs[v].data);
      tick(3);
    end

    // Burst "Hi\n" on consecutive cycles; frames must chain without a gap
    mon_q.delete();
    tx_valid = 1'b1;
    tx_data  = 8'h48;
    tick(1);
    tx_data  = 8'h69;
    tick(1);
    tx_data  = 8'h0A;
    tick(1);
    tx_valid = 1'b0;
    chk("burst_level", fifo_level, 5'd2);
    check_frame(fr(10'b1_01001000_0, 1'b0), 1, "burst_H");
    chk("b2b_start2", ser_tx, 1'b0);
    check_frame(fr(10'b1_01101001_0, 1'b0), 0, "burst_i");
    chk("b2b_start3", ser_tx, 1'b0);
    check_frame(fr(10'b1_00001010_0, 1'b0), 0, "burst_nl");
    chk("burst_busy", busy, 1'b0);
    tick(2);
    chk("burst_mon_cnt", mon_q.size(), 3);
    if (mon_q.size() == 3) begin
      chk("burst_mon0", mon_q[0], 8'h48);
      chk("burst_mon1", mon_q[1], 8'h69);
      chk("burst_mon2", mon_q[2], 8'h0A);
    end
    tick(5);

    // Full FIFO: sender holds each byte until accepted
    mon_q.delete();
    saw_full = 1'b0;
    i = 0;
    g = 0;
    while (i < 20 && g < 5000) begin
      tx_data  = 8'(i);
      tx_valid = 1'b1;
      r = tx_ready;
      if (fifo_level == 5'd16) begin
        saw_full = 1'b1;
        chk("ready_at_full", tx_ready, 1'b0);
      end else if (fifo_level < 5'd16) begin
        chk("ready_below_full", tx_ready, 1'b1);
      end
      tick(1);
      if (r) i++;
      g++;
    end
    tx_valid = 1'b0;
    chk("full_reached", saw_full, 1'b1);
    chk("full_all_pushed", i, 20);
    g = 0;
    while (mon_q.size() < 20 && g < 3000) begin
      tick(1);
      g++;
    end
    chk("full_mon_cnt", mon_q.size(), 20);
    for (int j = 0; j < 20 && j < mon_q.size(); j++) chk("full_order", mon_q[j], 32'(j));
    tick(20);
    chk("full_idle", busy, 1'b0);

    // Reset 35 clocks into a frame of 0xA3 with another byte queued
    push1(8'hA3);
    push1(8'h5A);
    tick(35);
    chk("pre_rst_ser", ser_tx, 1'b0);
    chk("pre_rst_level", fifo_level, 5'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_ser", ser_tx, 1'b1);
    chk("mid_rst_ready", tx_ready, 1'b1);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_level", fifo_level, 5'd0);
    @(negedge clk);
    rst = 1'b0;
    tick(120);
    chk("post_rst_idle", busy, 1'b0);
    mon_q.delete();
    push1(8'h41);
    tick(1);
    check_frame(fr(10'b1_01000001_0, 1'b0), 0, "post_rst_A");
    chk("post_rst_busy", busy, 1'b0);
    tick(2);
    chk("post_rst_mon_cnt", mon_q.size(), 1);
    if (mon_q.size() >= 1) chk("post_rst_mon", mon_q[0], 8'h41);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
